vend_dp_multi: RTL and testbench
================================

Name: vend_dp_multi

Overview:
Parametrised second-generation vending datapath with an integrated controller. It holds a per-product price/quantity table and accumulates coin deposits up to a ceiling. It validates a selection, decrements stock, and dispenses change coin by coin over a valid/ready handshake. It sits between the coin/keypad front-end and the dispenser/coin-return mechanics, replacing the split datapath-plus-external-control arrangement.

Parameters:
N_PROD, 32, number of products (table depth)
AW, 10, amount width; all money in 10-sen units
QW, 4, quantity width per product
MAX_DEP, 500, accumulated-deposit ceiling (units)
COIN_HI, 10, large change coin value (RM1)
COIN_LO, 1, small change coin value (10 sen)
INIT_PRICE, 50, reset price of every entry
INIT_QTY, 10, reset quantity of every entry

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low
dep_valid  in  1  one-cycle pulse: coin inserted
dep_amt  in  AW  coin value
sel_valid  in  1  one-cycle pulse: product selected
sel  in  $clog2(N_PROD)  product index
cancel  in  1  return whole balance
cfg_we  in  1  table write (honoured only in IDLE)
cfg_addr  in  $clog2(N_PROD)  table index
cfg_price  in  AW  new price
cfg_qty  in  QW  new quantity
vend  out  1  one-cycle pulse: dispense product
vend_prod  out  $clog2(N_PROD)  product dispensed, valid with vend
coin_rej  out  1  one-cycle pulse: inserted coin returned unaccepted
err_soldout  out  1  one-cycle pulse: selection has quantity 0
err_funds  out  1  one-cycle pulse: balance < price
chg_valid  out  1  change coin presented
chg_coin  out  1  0 = COIN_LO, 1 = COIN_HI
chg_ready  in  1  coin mechanism accepted coin
balance  out  AW  current accumulated deposit
busy  out  1  high in CHECK/VEND/CHANGE

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; balance 0; all pulse outputs, chg_valid and busy 0; vend_prod 0; every table entry = {INIT_QTY, INIT_PRICE}. Reset mid-CHANGE abandons outstanding change without any further chg_valid.
- States: IDLE, CHECK, VEND, CHANGE.
- IDLE, dep_valid: if balance+dep_amt <= MAX_DEP (sum computed AW+1 wide), balance updates next cycle; otherwise balance is unchanged and coin_rej pulses the next cycle.
- IDLE, sel_valid: latch sel and go to CHECK. Priority within one cycle: cancel > sel_valid > dep_valid. A losing dep_valid pulses coin_rej.
- IDLE, cancel: with balance>0 go to CHANGE (amount=balance); with balance==0 stay in IDLE (no-op).
- CHECK, one cycle: qty==0 -> err_soldout, back to IDLE, balance kept. Otherwise balance<price -> err_funds, IDLE, balance kept. Otherwise -> VEND. Soldout outranks funds.
- VEND, one cycle: vend=1, vend_prod=latched sel, qty decremented (never wraps; guaranteed >0). Remainder = balance-price; balance is cleared. Remainder>0 -> CHANGE, else IDLE.
- Latency: sel_valid to vend is 2 cycles (sel_valid in cycle t, CHECK in t+1, vend in t+2).
- CHANGE: greedy dispensing, one coin per handshake. chg_coin=1 while remaining>=COIN_HI, else 0. chg_valid stays high and chg_coin stable until chg_ready is sampled high. remaining decrements on each accepted coin. Leave to IDLE the cycle after remaining<COIN_LO; any residual below COIN_LO is discarded. chg_ready with chg_valid low is ignored.
- Inputs outside IDLE: dep_valid pulses coin_rej; sel_valid, cancel and cfg_we are ignored.
- cfg_we in IDLE writes price and quantity at cfg_addr; the written values are visible to CHECK on the next cycle. Out-of-range indices (>= N_PROD) on sel or cfg_addr are treated as sold out and a write, respectively, is dropped.

Optional Feature:
AUDIT_CNT_EN
- Defined: adds output sales_total (AW+8 bits, saturating), incremented by price at each vend, and output vend_count (16 bits, saturating). Both clear only on reset.
- Undefined: neither port nor register exists; all other behaviour is identical.

Decomposition:
- Package vend_pkg: state enum type, coin code constants (COIN_LO_C=0, COIN_HI_C=1), and the table entry struct {qty, price}.
- One natural sub-module: vend_chg_disp, which holds the remaining-amount register, makes the greedy coin choice, and runs the valid/ready handshake. It takes a start pulse and amount and returns done.

Test Plan:
1. Reset, deposit 50+20, select 0 (price 50) -> vend at t+2 with vend_prod=0; then coins HI,HI; qty[0]=9; balance=0.
2. Balance 495, deposit 10 -> coin_rej pulse; balance stays 495.
3. cfg_we addr 3 qty 0, select 3 -> err_soldout; balance unchanged; no vend.
4. Balance 30, select product priced 50 -> err_funds; then cancel -> coins HI,HI,HI; IDLE.
5. Balance 23, cancel, chg_ready held low 5 cycles -> chg_valid high, chg_coin=1 stable; then ready -> sequence HI,HI,LO,LO,LO.
6. sel_valid and dep_valid in the same cycle -> coin_rej plus CHECK; cancel asserted in CHANGE -> ignored.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types for the vending datapath: controller states, change-coin codes
// and the default-width price/quantity table entry.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_VEND,
        ST_CHANGE
    } state_e;

    localparam logic COIN_LO_C = 1'b0;
    localparam logic COIN_HI_C = 1'b1;

    localparam int unsigned DEF_AW = 10;
    localparam int unsigned DEF_QW = 4;

    typedef struct packed {
        logic [DEF_QW-1:0] qty;
        logic [DEF_AW-1:0] price;
    } tbl_entry_t;

endpackage

// File: rtl/vend_chg_disp.sv
// Change dispenser: loads an amount on start, pays it out greedily one coin per
// valid/ready handshake and flags done once less than the small coin remains.
module vend_chg_disp
    import vend_pkg::*;
#(
    parameter int unsigned AW      = 10,
    parameter int unsigned COIN_HI = 10,
    parameter int unsigned COIN_LO = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] amt,
    input  logic          chg_ready,
    output logic          chg_valid,
    output logic          chg_coin,
    output logic          done
);

    logic [AW-1:0] rem_q, rem_d;
    logic          active_q, active_d;
    logic          has_coin;

    always_comb begin
        has_coin  = rem_q >= AW'(COIN_LO);
        chg_valid = active_q && has_coin;
        chg_coin  = (rem_q >= AW'(COIN_HI)) ? COIN_HI_C : COIN_LO_C;
        done      = active_q && !has_coin;

        rem_d    = rem_q;
        active_d = active_q;
        if (start) begin
            rem_d    = amt;
            active_d = 1'b1;
        end else if (done) begin
            active_d = 1'b0;
        end else if (chg_valid && chg_ready) begin
            rem_d = rem_q - ((chg_coin == COIN_HI_C) ? AW'(COIN_HI) : AW'(COIN_LO));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rem_q    <= '0;
            active_q <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/vend_dp_multi.sv
// Vending datapath with integrated controller: price/qty table, deposit
// accumulator, selection check and change dispensing. AUDIT_CNT_EN adds sales counters.
module vend_dp_multi
    import vend_pkg::*;
#(
    parameter int unsigned N_PROD     = 32,
    parameter int unsigned AW         = DEF_AW,
    parameter int unsigned QW         = DEF_QW,
    parameter int unsigned MAX_DEP    = 500,
    parameter int unsigned COIN_HI    = 10,
    parameter int unsigned COIN_LO    = 1,
    parameter int unsigned INIT_PRICE = 50,
    parameter int unsigned INIT_QTY   = 10,
    localparam int unsigned SW        = $clog2(N_PROD)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dep_valid,
    input  logic [AW-1:0] dep_amt,
    input  logic          sel_valid,
    input  logic [SW-1:0] sel,
    input  logic          cancel,
    input  logic          cfg_we,
    input  logic [SW-1:0] cfg_addr,
    input  logic [AW-1:0] cfg_price,
    input  logic [QW-1:0] cfg_qty,
    output logic          vend,
    output logic [SW-1:0] vend_prod,
    output logic          coin_rej,
    output logic          err_soldout,
    output logic          err_funds,
    output logic          chg_valid,
    output logic          chg_coin,
    input  logic          chg_ready,
`ifdef AUDIT_CNT_EN
    output logic [AW+7:0] sales_total,
    output logic [15:0]   vend_count,
`endif
    output logic [AW-1:0] balance,
    output logic          busy
);

    typedef struct packed {
        logic [QW-1:0] qty;
        logic [AW-1:0] price;
    } entry_t;

    state_e        state_q, state_d;
    logic [AW-1:0] bal_q, bal_d;
    logic [SW-1:0] sel_q, sel_d;
    logic          rej_q, rej_d;
    entry_t        tbl_q [N_PROD];

    logic          tbl_we;
    logic [SW-1:0] tbl_waddr;
    entry_t        tbl_wdata;
    entry_t        rd_entry;
    logic          sel_ok, soldout, short_funds;
    logic [AW:0]   dep_sum;
    logic [AW-1:0] remain;
    logic          chg_start, chg_done;
    logic [AW-1:0] chg_amt;

`ifdef AUDIT_CNT_EN
    logic [AW+7:0] sales_q, sales_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [AW+8:0] sales_sum;
    assign sales_total = sales_q;
    assign vend_count  = cnt_q;
`endif

    // Out-of-range selections read as an empty entry so they fall out as sold out.
    assign sel_ok      = 32'(sel_q) < N_PROD;
    assign rd_entry    = sel_ok ? tbl_q[sel_q] : '0;
    assign soldout     = rd_entry.qty == '0;
    assign short_funds = bal_q < rd_entry.price;
    assign dep_sum     = {1'b0, bal_q} + {1'b0, dep_amt};
    assign remain      = bal_q - rd_entry.price;

    always_comb begin
        state_d   = state_q;
        bal_d     = bal_q;
        sel_d     = sel_q;
        rej_d     = 1'b0;
        tbl_we    = 1'b0;
        tbl_waddr = cfg_addr;
        tbl_wdata = '{qty: cfg_qty, price: cfg_price};
        chg_start = 1'b0;
        chg_amt   = '0;
`ifdef AUDIT_CNT_EN
        sales_d   = sales_q;
        cnt_d     = cnt_q;
        sales_sum = {1'b0, sales_q} + (AW+9)'(rd_entry.price);
`endif
        unique case (state_q)
            ST_IDLE: begin
                tbl_we = cfg_we && (32'(cfg_addr) < N_PROD);
                if (cancel) begin
                    rej_d = dep_valid;
                    if (bal_q != '0) begin
                        state_d   = ST_CHANGE;
                        chg_start = 1'b1;
                        chg_amt   = bal_q;
                        bal_d     = '0;
                    end
                end else if (sel_valid) begin
                    rej_d   = dep_valid;
                    sel_d   = sel;
                    state_d = ST_CHECK;
                end else if (dep_valid) begin
                    if (dep_sum <= (AW+1)'(MAX_DEP)) bal_d = dep_sum[AW-1:0];
                    else rej_d = 1'b1;
                end
            end
            ST_CHECK: begin
                rej_d = dep_valid;
                if (soldout || short_funds) state_d = ST_IDLE;
                else state_d = ST_VEND;
            end
            ST_VEND: begin
                rej_d     = dep_valid;
                tbl_we    = 1'b1;
                tbl_waddr = sel_q;
                tbl_wdata = '{qty: rd_entry.qty - QW'(1), price: rd_entry.price};
                bal_d     = '0;
`ifdef AUDIT_CNT_EN
                sales_d = sales_sum[AW+8] ? '1 : sales_sum[AW+7:0];
                cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;
`endif
                if (remain != '0) begin
                    state_d   = ST_CHANGE;
                    chg_start = 1'b1;
                    chg_amt   = remain;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHANGE: begin
                rej_d = dep_valid;
                if (chg_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        vend        = state_q == ST_VEND;
        vend_prod   = vend ? sel_q : '0;
        err_soldout = (state_q == ST_CHECK) && soldout;
        err_funds   = (state_q == ST_CHECK) && !soldout && short_funds;
        busy        = state_q != ST_IDLE;
        coin_rej    = rej_q;
        balance     = bal_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            bal_q   <= '0;
            sel_q   <= '0;
            rej_q   <= 1'b0;
`ifdef AUDIT_CNT_EN
            sales_q <= '0;
            cnt_q   <= '0;
`endif
            for (int unsigned i = 0; i < N_PROD; i++)
                tbl_q[i] <= '{qty: QW'(INIT_QTY), price: AW'(INIT_PRICE)};
        end else begin
            state_q <= state_d;
            bal_q   <= bal_d;
            sel_q   <= sel_d;
            rej_q   <= rej_d;
`ifdef AUDIT_CNT_EN
            sales_q <= sales_d;
            cnt_q   <= cnt_d;
`endif
            if (tbl_we) tbl_q[tbl_waddr] <= tbl_wdata;
        end
    end

    vend_chg_disp #(
        .AW      (AW),
        .COIN_HI (COIN_HI),
        .COIN_LO (COIN_LO)
    ) u_chg (
        .clk       (clk),
        .rst       (rst),
        .start     (chg_start),
        .amt       (chg_amt),
        .chg_ready (chg_ready),
        .chg_valid (chg_valid),
        .chg_coin  (chg_coin),
        .done      (chg_done)
    );

endmodule

// File: tb/tb_vend_dp_multi.sv
// Directed self-checking bench for vend_dp_multi with default parameters.
module tb_vend_dp_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic       dep_valid, sel_valid, cancel, cfg_we, chg_ready;
    logic [9:0] dep_amt, cfg_price, balance;
    logic [4:0] sel, cfg_addr, vend_prod;
    logic [3:0] cfg_qty;
    logic       vend, coin_rej, err_soldout, err_funds, chg_valid, chg_coin, busy;
`ifdef AUDIT_CNT_EN
    logic [17:0] sales_total;
    logic [15:0] vend_count;
`endif

    int checks = 0;
    int errors = 0;

    vend_dp_multi dut (
        .clk         (clk),
        .rst         (rst),
        .dep_valid   (dep_valid),
        .dep_amt     (dep_amt),
        .sel_valid   (sel_valid),
        .sel         (sel),
        .cancel      (cancel),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_price   (cfg_price),
        .cfg_qty     (cfg_qty),
        .vend        (vend),
        .vend_prod   (vend_prod),
        .coin_rej    (coin_rej),
        .err_soldout (err_soldout),
        .err_funds   (err_funds),
        .chg_valid   (chg_valid),
        .chg_coin    (chg_coin),
        .chg_ready   (chg_ready),
`ifdef AUDIT_CNT_EN
        .sales_total (sales_total),
        .vend_count  (vend_count),
`endif
        .balance     (balance),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic deposit(input logic [9:0] amt);
        dep_valid = 1'b1;
        dep_amt   = amt;
        tick();
        dep_valid = 1'b0;
    endtask

    task automatic select(input logic [4:0] idx);
        sel_valid = 1'b1;
        sel       = idx;
        tick();
        sel_valid = 1'b0;
    endtask

    // Called with the DUT already in CHANGE; walks the expected greedy coin sequence.
    task automatic expect_change(input int n_hi, input int n_lo, input int stall);
        for (int s = 0; s < stall; s++) begin
            check("stall_valid", 32'(chg_valid), 32'd1);
            check("stall_coin", 32'(chg_coin), (n_hi > 0) ? 32'd1 : 32'd0);
            tick();
        end
        for (int i = 0; i < n_hi + n_lo; i++) begin
            check("chg_valid", 32'(chg_valid), 32'd1);
            check("chg_coin", 32'(chg_coin), (i < n_hi) ? 32'd1 : 32'd0);
            chg_ready = 1'b1;
            tick();
            chg_ready = 1'b0;
        end
        check("chg_end_valid", 32'(chg_valid), 32'd0);
        check("chg_end_busy", 32'(busy), 32'd1);
        tick();
        check("chg_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        dep_valid = 1'b0; dep_amt = '0; sel_valid = 1'b0; sel = '0; cancel = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_price = '0; cfg_qty = '0; chg_ready = 1'b0;
        tick();
        tick();
        check("rst_balance", 32'(balance), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_chg_valid", 32'(chg_valid), 32'd0);
        check("rst_vend", 32'(vend), 32'd0);
        check("rst_vend_prod", 32'(vend_prod), 32'd0);
        check("rst_coin_rej", 32'(coin_rej), 32'd0);
        rst = 1'b1;

        // 1: 50+20, buy product 0 at 50, change 20 as HI,HI
        deposit(10'd50);
        check("t1_bal50", 32'(balance), 32'd50);
        deposit(10'd20);
        check("t1_bal70", 32'(balance), 32'd70);
        select(5'd0);
        check("t1_check_busy", 32'(busy), 32'd1);
        check("t1_check_vend", 32'(vend), 32'd0);
        check("t1_check_err", 32'({err_soldout, err_funds}), 32'd0);
        tick();
        check("t1_vend", 32'(vend), 32'd1);
        check("t1_vend_prod", 32'(vend_prod), 32'd0);
        tick();
        check("t1_vend_pulse", 32'(vend), 32'd0);
        check("t1_bal_clr", 32'(balance), 32'd0);
        expect_change(2, 0, 0);

        // 2: ceiling reject at 495+10
        deposit(10'd495);
        check("t2_bal495", 32'(balance), 32'd495);
        deposit(10'd10);
        check("t2_rej", 32'(coin_rej), 32'd1);
        check("t2_bal_kept", 32'(balance), 32'd495);
        tick();
        check("t2_rej_pulse", 32'(coin_rej), 32'd0);

        // 3: sold-out entry 3
        cfg_we = 1'b1; cfg_addr = 5'd3; cfg_price = 10'd50; cfg_qty = 4'd0;
        tick();
        cfg_we = 1'b0;
        select(5'd3);
        check("t3_soldout", 32'(err_soldout), 32'd1);
        check("t3_funds", 32'(err_funds), 32'd0);
        tick();
        check("t3_soldout_pulse", 32'(err_soldout), 32'd0);
        check("t3_no_vend", 32'(vend), 32'd0);
        check("t3_idle", 32'(busy), 32'd0);
        check("t3_bal", 32'(balance), 32'd495);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("t3_cancel_bal", 32'(balance), 32'd0);
        expect_change(49, 5, 0);

        // 4: insufficient funds, then cancel
        deposit(10'd30);
        select(5'd0);
        check("t4_funds", 32'(err_funds), 32'd1);
        check("t4_soldout", 32'(err_soldout), 32'd0);
        tick();
        check("t4_bal", 32'(balance), 32'd30);
        check("t4_no_vend", 32'(vend), 32'd0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        expect_change(3, 0, 0);

        // 5: 23 returned with a 5-cycle stall
        deposit(10'd23);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        expect_change(2, 3, 5);

        // 6: sel beats dep in one cycle; cancel during CHANGE ignored
        deposit(10'd60);
        sel_valid = 1'b1; sel = 5'd1; dep_valid = 1'b1; dep_amt = 10'd10;
        tick();
        sel_valid = 1'b0; dep_valid = 1'b0;
        check("t6_rej", 32'(coin_rej), 32'd1);
        check("t6_busy", 32'(busy), 32'd1);
        check("t6_bal", 32'(balance), 32'd60);
        tick();
        check("t6_vend", 32'(vend), 32'd1);
        check("t6_vend_prod", 32'(vend_prod), 32'd1);
        tick();
        cancel = 1'b1;
        expect_change(1, 0, 0);
        cancel = 1'b0;
        tick();
        check("t6_no_restart", 32'(busy), 32'd0);
        check("t6_bal0", 32'(balance), 32'd0);

        // 7: qty 1 entry sells once, then reads sold out
        cfg_we = 1'b1; cfg_addr = 5'd5; cfg_price = 10'd50; cfg_qty = 4'd1;
        tick();
        cfg_we = 1'b0;
        deposit(10'd50);
        select(5'd5);
        tick();
        check("t7_vend", 32'(vend), 32'd1);
        check("t7_vend_prod", 32'(vend_prod), 32'd5);
        tick();
        check("t7_idle", 32'(busy), 32'd0);
        check("t7_no_chg", 32'(chg_valid), 32'd0);
        deposit(10'd50);
        select(5'd5);
        check("t7_soldout", 32'(err_soldout), 32'd1);
        tick();
        check("t7_bal", 32'(balance), 32'd50);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        expect_change(5, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
